// File: rtl/ring_osc_freq_meter.sv
// ring_osc_freq_meter
// Enables a ring oscillator, lets it settle, then counts rising edges of its
// (asynchronous, synchronized) output over a programmable window of clk
// cycles and presents the result with a valid flag.
//
// Optional build macro: FREQ_METER_SATURATE_EN
//   defined   -> count saturates at all-ones and the sticky o_ovf port exists
//   undefined -> count wraps modulo 2^CNT_W and there is no o_ovf port
//
// Handshake: i_start is a single-cycle request, accepted only when the meter
// is not busy (IDLE or DONE); a start seen while busy is dropped and does not
// relatch i_win_len. o_count_valid is a level: it rises when the window
// closes and stays high, with o_count stable, until the next accepted start,
// an abort of a running measurement, or rst. i_abort only acts while busy and
// takes priority over i_start in the same cycle.

module ring_osc_freq_meter #(
    parameter int CNT_W       = 16,
    parameter int WIN_W       = 16,
    parameter int SETTLE      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [WIN_W-1:0] i_win_len,
    input  logic             i_osc_in,
    output logic             o_osc_en,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_count,
    output logic             o_count_valid,
`ifdef FREQ_METER_SATURATE_EN
    output logic             o_ovf,
`endif
    output logic [1:0]       o_dbg_state
);

    // ------------------------------------------------------------------
    // State encoding and constants
    // ------------------------------------------------------------------
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARM   = 2'd1;
    localparam logic [1:0] S_COUNT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // The settle timer runs SETTLE..0, so it needs to hold SETTLE itself.
    localparam int SET_W = $clog2(SETTLE + 1);

    localparam logic [SET_W-1:0] SETTLE_V = SET_W'(SETTLE);
    localparam logic [SET_W-1:0] SET_ONE  = SET_W'(1);
    localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // ------------------------------------------------------------------
    // Registers and internal wires
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic [1:0]             r_state;
    logic [WIN_W-1:0]       r_win;
    logic [WIN_W-1:0]       r_win_cnt;
    logic [SET_W-1:0]       r_settle;
    logic [CNT_W-1:0]       r_count;
    logic                   r_valid;
    logic                   r_osc_en;
`ifdef FREQ_METER_SATURATE_EN
    logic                   r_ovf;
`endif

    logic       w_rise;
    logic       w_meas;
    logic       w_start_acc;
    logic       w_abort_acc;
    logic [1:0] w_state_nxt;
    logic       w_nxt_meas;

    // ------------------------------------------------------------------
    // Synchronizer and rising-edge detector
    // ------------------------------------------------------------------

    // Bring the free-running oscillator into the clk domain; runs in every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_osc_in};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------

    // ARM and COUNT together form the "measurement in progress" window.
    assign w_meas      = (r_state == S_ARM) || (r_state == S_COUNT);
    assign w_abort_acc = i_abort && w_meas;
    assign w_start_acc = i_start && !w_meas;

    // Next-state decode: abort wins over everything while a measurement runs.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start_acc) begin
                    w_state_nxt = S_ARM;
                end
            end
            S_ARM: begin
                if (w_abort_acc) begin
                    w_state_nxt = S_IDLE;
                end else if (r_settle == '0) begin
                    // An empty window skips counting altogether.
                    w_state_nxt = (r_win == '0) ? S_DONE : S_COUNT;
                end
            end
            S_COUNT: begin
                if (w_abort_acc) begin
                    w_state_nxt = S_IDLE;
                end else if (r_win_cnt == '0) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_nxt_meas = (w_state_nxt == S_ARM) || (w_state_nxt == S_COUNT);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Settle and window timers
    // ------------------------------------------------------------------

    // Latch the window at accepted start; ARM spends SETTLE+1 cycles
    // (one launch cycle plus SETTLE with the oscillator enabled), then the
    // window timer counts win_len-1..0 through COUNT.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_win     <= '0;
            r_settle  <= '0;
            r_win_cnt <= '0;
        end else if (w_start_acc) begin
            r_win    <= i_win_len;
            r_settle <= SETTLE_V;
        end else if (r_state == S_ARM) begin
            if (r_settle != '0) begin
                r_settle <= r_settle - SET_ONE;
            end
            // Preloaded every ARM cycle; only the value at ARM->COUNT matters.
            r_win_cnt <= r_win - WIN_ONE;
        end else if (r_state == S_COUNT) begin
            r_win_cnt <= r_win_cnt - WIN_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Edge counter
    // ------------------------------------------------------------------

    // Count synchronized rising edges only while in COUNT.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
`ifdef FREQ_METER_SATURATE_EN
            r_ovf   <= 1'b0;
`endif
        end else if (w_start_acc || w_abort_acc) begin
            r_count <= '0;
`ifdef FREQ_METER_SATURATE_EN
            r_ovf   <= 1'b0;
`endif
        end else if ((r_state == S_COUNT) && w_rise) begin
`ifdef FREQ_METER_SATURATE_EN
            // Hold at all-ones and remember that an edge was lost.
            if (r_count == '1) begin
                r_ovf <= 1'b1;
            end else begin
                r_count <= r_count + CNT_ONE;
            end
`else
            r_count <= r_count + CNT_ONE;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Result valid and oscillator enable
    // ------------------------------------------------------------------

    // count_valid rises on entry to DONE and holds until the next start or abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
        end else if (w_start_acc || w_abort_acc) begin
            r_valid <= 1'b0;
        end else if (w_meas && (w_state_nxt == S_DONE)) begin
            r_valid <= 1'b1;
        end
    end

    // Enable trails the FSM by one cycle: off during the launch cycle,
    // on for SETTLE+win_len cycles, off again as DONE or IDLE is entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_osc_en <= 1'b0;
        end else begin
            r_osc_en <= w_meas && w_nxt_meas;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_osc_en      = r_osc_en;
    assign o_busy        = w_meas;
    assign o_count       = r_count;
    assign o_count_valid = r_valid;
    assign o_dbg_state   = r_state;
`ifdef FREQ_METER_SATURATE_EN
    assign o_ovf         = r_ovf;
`endif

endmodule
